// File: rtl/sound_mixer.sv
// Four-channel stereo mixer: captures channel levels and routing on a tick,
// accumulates per side over four cycles, then scales by master volume.
module sound_mixer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] level1,
  input  logic [3:0] level2,
  input  logic [3:0] level3,
  input  logic [3:0] level4,
  input  logic [3:0] ch_enable,
  input  logic [7:0] panning,
  input  logic [2:0] left_vol,
  input  logic [2:0] right_vol,
  input  logic       master_en,
  input  logic       sample_tick,
  output logic [8:0] left,
  output logic [8:0] right,
  output logic       sample_valid,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    ACC     = 3'd2,
    SCALE   = 3'd3,
    OUT     = 3'd4
  } state_t;

  state_t      state_r;
  logic [15:0] levels_r;
  logic [3:0]  en_r;
  logic [7:0]  pan_r;
  logic [2:0]  lvol_r;
  logic [2:0]  rvol_r;
  logic        men_r;
  logic [5:0]  acc_l_r;
  logic [5:0]  acc_r_r;
  logic [1:0]  idx_r;
  logic [8:0]  scl_l_r;
  logic [8:0]  scl_r_r;

  logic [3:0]  cur_lvl_s;
  logic        add_l_s;
  logic        add_r_s;

  // acc * (vol + 1) as a sum of shifted partial products
  function automatic logic [8:0] scale_mul(input logic [5:0] acc, input logic [2:0] vol);
    logic [3:0] m;
    logic [8:0] sum;
    m   = {1'b0, vol} + 4'd1;
    sum = 9'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        sum = sum + ({3'd0, acc} << i);
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

  // Select the latched level and routing bits of the channel being accumulated
  always_comb begin
    cur_lvl_s = levels_r[{idx_r, 2'b00} +: 4];
    add_l_s   = en_r[idx_r] & pan_r[{1'b1, idx_r}];
    add_r_s   = en_r[idx_r] & pan_r[{1'b0, idx_r}];
  end

  // Mix sequencer with registered outputs; reset wins over any tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      levels_r     <= 16'd0;
      en_r         <= 4'd0;
      pan_r        <= 8'd0;
      lvol_r       <= 3'd0;
      rvol_r       <= 3'd0;
      men_r        <= 1'b0;
      acc_l_r      <= 6'd0;
      acc_r_r      <= 6'd0;
      idx_r        <= 2'd0;
      scl_l_r      <= 9'd0;
      scl_r_r      <= 9'd0;
      left         <= 9'd0;
      right        <= 9'd0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (sample_tick) begin
            state_r <= CAPTURE;
            busy    <= 1'b1;
          end
        end
        CAPTURE: begin
          levels_r <= {level4, level3, level2, level1};
          en_r     <= ch_enable;
          pan_r    <= panning;
          lvol_r   <= left_vol;
          rvol_r   <= right_vol;
          men_r    <= master_en;
          acc_l_r  <= 6'd0;
          acc_r_r  <= 6'd0;
          idx_r    <= 2'd0;
          state_r  <= ACC;
        end
        ACC: begin
          if (add_l_s) acc_l_r <= acc_l_r + {2'd0, cur_lvl_s};
          if (add_r_s) acc_r_r <= acc_r_r + {2'd0, cur_lvl_s};
          idx_r <= idx_r + 2'd1;
          if (idx_r == 2'd3) state_r <= SCALE;
        end
        SCALE: begin
          scl_l_r <= men_r ? scale_mul(acc_l_r, lvol_r) : 9'd0;
          scl_r_r <= men_r ? scale_mul(acc_r_r, rvol_r) : 9'd0;
          state_r <= OUT;
        end
        OUT: begin
          left         <= scl_l_r;
          right        <= scl_r_r;
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
// Self-checking bench for sound_mixer: directed cases with literal results
// plus randomized traffic compared each cycle against a behavioural model.
module tb_sound_mixer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] level1, level2, level3, level4;
  logic [3:0] ch_enable;
  logic [7:0] panning;
  logic [2:0] left_vol, right_vol;
  logic       master_en;
  logic       sample_tick;
  logic [8:0] left, right;
  logic       sample_valid, busy, overrun;

  int compared   = 0;
  int mismatched = 0;

  sound_mixer dut (
    .clk(clk), .rst(rst),
    .level1(level1), .level2(level2), .level3(level3), .level4(level4),
    .ch_enable(ch_enable), .panning(panning),
    .left_vol(left_vol), .right_vol(right_vol),
    .master_en(master_en), .sample_tick(sample_tick),
    .left(left), .right(right), .sample_valid(sample_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase = cycles elapsed since an accepted tick (0 = idle)
  int phase = 0;
  int exp_left = 0, exp_right = 0, res_left = 0, res_right = 0;
  bit exp_valid = 1'b0, exp_ov = 1'b0, exp_busy = 1'b0;
  bit model_live = 1'b0;

  always @(posedge clk) begin
    int lv[4];
    int sl, sr;
    if (rst) begin
      phase = 0; exp_left = 0; exp_right = 0;
      exp_valid = 1'b0; exp_ov = 1'b0;
      model_live = 1'b1;
    end else begin
      exp_valid = 1'b0;
      if (phase == 0) begin
        if (sample_tick) phase = 1;
      end else begin
        if (sample_tick) exp_ov = 1'b1;
        if (phase == 1) begin
          lv = '{int'(level1), int'(level2), int'(level3), int'(level4)};
          sl = 0; sr = 0;
          for (int n = 0; n < 4; n++) begin
            if (ch_enable[n] && panning[4+n]) sl += lv[n];
            if (ch_enable[n] && panning[n])   sr += lv[n];
          end
          res_left  = master_en ? sl * (int'(left_vol) + 1)  : 0;
          res_right = master_en ? sr * (int'(right_vol) + 1) : 0;
        end
        if (phase == 7) begin
          exp_left = res_left; exp_right = res_right;
          exp_valid = 1'b1;
          phase = 0;
        end else begin
          phase = phase + 1;
        end
      end
    end
    exp_busy = (phase != 0);
  end

  // Compare every cycle on the falling edge once the model has seen reset
  always @(negedge clk) begin
    if (model_live) begin
      chk("left", int'(left), exp_left);
      chk("right", int'(right), exp_right);
      chk("sample_valid", int'(sample_valid), int'(exp_valid));
      chk("busy", int'(busy), int'(exp_busy));
      chk("overrun", int'(overrun), int'(exp_ov));
    end
  end

  task automatic set_all(input logic [3:0] l1, l2, l3, l4, en,
                         input logic [7:0] pan, input logic [2:0] lvl, rvl,
                         input logic men);
    level1 = l1; level2 = l2; level3 = l3; level4 = l4;
    ch_enable = en; panning = pan; left_vol = lvl; right_vol = rvl; master_en = men;
  endtask

  // act: 0 plain, 1 disturb inputs after capture, 2 second tick, 3 reset mid-mix
  task automatic do_mix(input string nm, input int act, input bit want_valid,
                        input int el, input int er);
    int cnt;
    bit found;
    found = 1'b0;
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    cnt = 1;
    while (cnt < 12) begin
      @(negedge clk);
      if (sample_valid && !found) begin
        found = 1'b1;
        chk({nm, "_latency"}, cnt, 8);
        chk({nm, "_left"}, int'(left), el);
        chk({nm, "_right"}, int'(right), er);
      end
      @(posedge clk); #1;
      cnt++;
      if (act == 1 && cnt == 2) begin
        level1 = 4'd7; level2 = 4'd7; ch_enable = 4'hF; master_en = 1'b1;
      end
      if (act == 2) sample_tick = (cnt == 3);
      if (act == 3) rst = (cnt == 3);
    end
    chk({nm, "_valid_seen"}, int'(found), int'(want_valid));
  endtask

  initial begin
    rst = 1'b1; sample_tick = 1'b0;
    set_all(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 3'd0, 3'd0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_left", int'(left), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);

    set_all(4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 8'hFF, 3'd7, 3'd7, 1'b1);
    do_mix("full", 0, 1'b1, 480, 480);
    set_all(4'd5, 4'd3, 4'd9, 4'd2, 4'hF, 8'h12, 3'd1, 3'd0, 1'b1);
    do_mix("pan12", 0, 1'b1, 10, 3);
    set_all(4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 8'hFF, 3'd7, 3'd7, 1'b0);
    do_mix("muted", 0, 1'b1, 0, 0);
    set_all(4'd15, 4'd15, 4'd15, 4'd15, 4'h0, 8'hFF, 3'd7, 3'd7, 1'b1);
    do_mix("latched", 1, 1'b1, 0, 0);
    set_all(4'd4, 4'd0, 4'd0, 4'd0, 4'h1, 8'h11, 3'd2, 3'd3, 1'b1);
    do_mix("overrun", 2, 1'b1, 12, 16);
    chk("overrun_sticky", int'(overrun), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("overrun_held", int'(overrun), 1);
    set_all(4'd9, 4'd9, 4'd9, 4'd9, 4'hF, 8'hFF, 3'd3, 3'd3, 1'b1);
    do_mix("abort", 3, 1'b0, 0, 0);
    chk("abort_left", int'(left), 0);
    chk("abort_overrun", int'(overrun), 0);
    do_mix("after_abort", 0, 1'b1, 144, 144);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      level1 = 4'($urandom_range(0, 15));
      level2 = 4'($urandom_range(0, 15));
      level3 = 4'($urandom_range(0, 15));
      level4 = 4'($urandom_range(0, 15));
      ch_enable = 4'($urandom_range(0, 15));
      panning   = 8'($urandom_range(0, 255));
      left_vol  = 3'($urandom_range(0, 7));
      right_vol = 3'($urandom_range(0, 7));
      master_en = ($urandom_range(0, 7) != 0);
      sample_tick = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; sample_tick = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
